// File: rtl/ex_stage.sv
// Execute stage: operand select, ALU, EX/MEM register, optional iterative multiplier with HI/LO.
// Latency: 1 cycle to EX/MEM; mult/multu hold the pipeline for 33 cycles.
// Backpressure: stall_out freezes PC, IF/ID and ID/EX; EX/MEM receives a bubble while stalled.
//
// Optional feature macro: EX_MULT_EN (multiplier FSM, HI/LO, mfhi/mflo/mult/multu).
// Ports:
//   clk, rst (sync, active-high)
//   ALUOp_in, funct_in, shamt_in, rt_in, rd_in, rfile_rd1, rfile_rd2, extend_immed_in,
//   RegDst_in, ALUSrc_in, MemtoReg_in, RegWrite_in, MemRead_in, MemWrite_in   - ID/EX fields
//   alu_result_out, wr_data_out, wr_reg_out, MemtoReg_out, RegWrite_out,
//   MemRead_out, MemWrite_out                                                  - EX/MEM register
//   stall_out                                                                  - upstream hold
module ex_stage #(
    parameter int MUL_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  ALUOp_in,
    input  logic [5:0]  funct_in,
    input  logic [4:0]  shamt_in,
    input  logic [4:0]  rt_in,
    input  logic [4:0]  rd_in,
    input  logic [31:0] rfile_rd1,
    input  logic [31:0] rfile_rd2,
    input  logic [31:0] extend_immed_in,
    input  logic        RegDst_in,
    input  logic        ALUSrc_in,
    input  logic        MemtoReg_in,
    input  logic        RegWrite_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    output logic [31:0] alu_result_out,
    output logic [31:0] wr_data_out,
    output logic [4:0]  wr_reg_out,
    output logic        MemtoReg_out,
    output logic        RegWrite_out,
    output logic        MemRead_out,
    output logic        MemWrite_out,
    output logic        stall_out
);

    // The shift-add datapath below is sized for exactly 32 iterations.
    if (MUL_CYCLES != 32) begin : g_cfg_check
        $error("ex_stage: MUL_CYCLES must be 32");
    end

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  wr_reg_d;
    logic [31:0] alu_res_d;
    logic        gpr_wr_ok;
    logic        stall;

    logic [31:0] alu_result_q;
    logic [31:0] wr_data_q;
    logic [4:0]  wr_reg_q;
    logic        mem_to_reg_q;
    logic        reg_write_q;
    logic        mem_read_q;
    logic        mem_write_q;

`ifdef EX_MULT_EN
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [63:0] mcand_q;
    logic [31:0] mplier_q;
    logic [63:0] acc_q;
    logic        neg_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        is_mul;
    logic        is_signed;
    logic [63:0] acc_d;
`endif

    assign op_a     = rfile_rd1;
    assign op_b     = ALUSrc_in ? extend_immed_in : rfile_rd2;
    assign wr_reg_d = RegDst_in ? rd_in : rt_in;

    always_comb begin
        alu_res_d = 32'd0;
        gpr_wr_ok = 1'b1;
`ifdef EX_MULT_EN
        is_mul    = 1'b0;
`endif
        case (ALUOp_in)
            2'b00: alu_res_d = op_a + op_b;
            2'b01: alu_res_d = op_a - op_b;
            2'b11: alu_res_d = op_a | op_b;
            default: begin
                case (funct_in)
                    6'h20, 6'h21: alu_res_d = op_a + op_b;
                    6'h22, 6'h23: alu_res_d = op_a - op_b;
                    6'h24: alu_res_d = op_a & op_b;
                    6'h25: alu_res_d = op_a | op_b;
                    6'h26: alu_res_d = op_a ^ op_b;
                    6'h27: alu_res_d = ~(op_a | op_b);
                    6'h2A: alu_res_d = {31'd0, $signed(op_a) < $signed(op_b)};
                    6'h2B: alu_res_d = {31'd0, op_a < op_b};
                    6'h00: alu_res_d = op_b << shamt_in;
                    6'h02: alu_res_d = op_b >> shamt_in;
                    6'h03: alu_res_d = $unsigned($signed(op_b) >>> shamt_in);
`ifdef EX_MULT_EN
                    6'h10: alu_res_d = hi_q;
                    6'h12: alu_res_d = lo_q;
                    // Multiplies produce no GPR result; HI/LO are written by the FSM.
                    6'h18, 6'h19: begin
                        is_mul    = 1'b1;
                        gpr_wr_ok = 1'b0;
                    end
`endif
                    default: gpr_wr_ok = 1'b0;
                endcase
            end
        endcase
    end

`ifdef EX_MULT_EN
    assign is_signed = ~funct_in[0];
    assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
    // In IDLE the stall is raised combinationally so the mult is held from its first cycle.
    assign stall     = ~rst & (((state_q == S_IDLE) & is_mul) | (state_q == S_BUSY));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            mcand_q  <= 64'd0;
            mplier_q <= 32'd0;
            acc_q    <= 64'd0;
            neg_q    <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (is_mul) begin
                        // Signed multiply works on magnitudes and fixes the sign at the end.
                        mcand_q  <= {32'd0, (is_signed & op_a[31]) ? -op_a : op_a};
                        mplier_q <= (is_signed & op_b[31]) ? -op_b : op_b;
                        neg_q    <= is_signed & (op_a[31] ^ op_b[31]);
                        acc_q    <= 64'd0;
                        cnt_q    <= 5'd0;
                        state_q  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 5'd1;
                    if (cnt_q == 5'(MUL_CYCLES - 1)) begin
                        {hi_q, lo_q} <= neg_q ? -acc_d : acc_d;
                        state_q      <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;   // DONE: held mult is consumed this cycle
            endcase
        end
    end
`else
    assign stall = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_result_q <= 32'd0;
            wr_data_q    <= 32'd0;
            wr_reg_q     <= 5'd0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
        end else if (stall) begin
            // Bubble: kill side effects, keep the data fields.
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            alu_result_q <= alu_res_d;
            wr_data_q    <= rfile_rd2;
            wr_reg_q     <= wr_reg_d;
            mem_to_reg_q <= MemtoReg_in;
            reg_write_q  <= RegWrite_in & gpr_wr_ok;
            mem_read_q   <= MemRead_in;
            mem_write_q  <= MemWrite_in;
        end
    end

    assign alu_result_out = alu_result_q;
    assign wr_data_out    = wr_data_q;
    assign wr_reg_out     = wr_reg_q;
    assign MemtoReg_out   = mem_to_reg_q;
    assign RegWrite_out   = reg_write_q;
    assign MemRead_out    = mem_read_q;
    assign MemWrite_out   = mem_write_q;
    assign stall_out      = stall;

endmodule
